// File: rtl/binarize_pack.sv
// Sign-binarizes a signed activation stream and packs M bits per word behind a one-word output buffer.
// Optional build macro BINARIZE_THRESH_EN adds a per-beat signed threshold input thr.
module binarize_pack #(
  parameter int DATA_W = 8,
  parameter int M      = 3,
  parameter int M_log2 = $clog2(M + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
`ifdef BINARIZE_THRESH_EN
  input  logic signed [DATA_W-1:0] thr,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [M-1:0]             out_a,
  output logic [M_log2-1:0]        out_fill,
  output logic                     out_last
);

  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(M - 1);

  logic [M-1:0]      acc;
  logic [IDX_W-1:0]  idx;
  logic              bit_p0;
  logic              complete_p0;
  logic              accept_p0;
  logic [M-1:0]      word_p0;

  function automatic logic binarize(input logic signed [DATA_W-1:0] x,
                                    input logic signed [DATA_W-1:0] t);
    return (x >= t);
  endfunction

`ifdef BINARIZE_THRESH_EN
  assign bit_p0 = binarize(in_data, thr);
`else
  assign bit_p0 = binarize(in_data, '0);
`endif

  // A completing beat can only be taken if the output buffer is free or draining now.
  assign complete_p0 = (idx == IDX_MAX) || in_last;
  assign in_ready    = !complete_p0 || !out_valid || out_ready;
  assign accept_p0   = in_valid && in_ready;

  always_comb begin
    word_p0 = '0;
    for (int k = 0; k < M; k++) begin
      if (k < int'(idx))
        word_p0[k] = acc[k];
      else if (k == int'(idx))
        word_p0[k] = bit_p0;
    end
  end

  // Stage p0 -> output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_fill  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept_p0) begin
        if (complete_p0) begin
          out_a    <= word_p0;
          out_fill <= M_log2'(idx) + M_log2'(1);
          out_last <= in_last;
          acc      <= '0;
          idx      <= '0;
        end else begin
          acc[idx] <= bit_p0;
          idx      <= idx + IDX_W'(1);
        end
      end
      if (accept_p0 && complete_p0)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/binarize_pack.md
Name: binarize_pack

Overview:
- Producer for the XNOR-majority datapath.
- Accepts a stream of signed multi-bit activations, one per cycle.
- Binarizes each activation by sign and packs M consecutive bits into the M-bit activation vector the XNOR-majority units consume.
- Valid/ready handshake on both sides, with a one-word output buffer so packing continues while the consumer stalls.

Parameters:
- DATA_W, 8: width of the signed input activation.
- M, 3: bits per packed output word; must match the XNOR-majority M.
- M_log2, $clog2(M+1): width of the fill-count output.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  DATA_W  signed two's-complement activation.
- in_last  input  1  final element of the vector; flushes a partial word.
- out_valid  output  1  out_a holds a word.
- out_ready  input  1  consumer takes the word this cycle.
- out_a  output  M  packed binarized word; element k of the word is at bit k (first element at LSB).
- out_fill  output  M_log2  number of valid bits in out_a (1..M).
- out_last  output  1  word closes a vector.

Behaviour:
- Binarization: bit = 1 when in_data >= 0 (MSB clear), else 0. No other arithmetic.
- Accept: a beat is accepted when in_valid && in_ready.
- Internal state:
  - Accumulator acc[M-1:0].
  - Index idx, range 0..M-1.
  - Output register: out_a, out_fill, out_last, out_valid.
- Accepted beat, non-completing (idx < M-1 and !in_last):
  - acc[idx] <= bit.
  - idx <= idx+1.
- Accepted beat, completing (idx == M-1 or in_last):
  - Output register loads: out_a = acc with bit inserted at idx, bits above idx forced to 0; out_fill = idx+1; out_last = in_last.
  - out_valid <= 1.
  - acc <= 0, idx <= 0.
- in_ready:
  - 1 when the beat would not complete a word.
  - Otherwise 1 only if !out_valid || out_ready.
  - Combinational from idx, out_valid, out_ready. It does not depend on in_valid, but does depend on in_last.
- Output:
  - out_valid clears on out_ready when no new word loads in the same cycle.
  - Simultaneous drain and load: the new word replaces the old with out_valid held at 1, giving full throughput of one word every M cycles.
- Output stability: while out_valid && !out_ready, out_a/out_fill/out_last hold stable.
- Latency: completing beat at cycle t gives out_valid at t+1.
- Boundaries:
  - M == 1: every accepted beat completes a word.
  - in_last at idx 0: out_fill = 1.
  - in_last at idx M-1: a normal full word with out_last = 1.
- Reset (async, any time, including mid-word): all of acc, idx, out_valid, out_a, out_fill, out_last go to 0. A partial word is discarded. in_ready evaluates to 1 after reset.
- No overflow is possible: the stall is expressed only through in_ready.

Optional Feature:
- Macro BINARIZE_THRESH_EN.
- Defined:
  - Adds input port thr, DATA_W bits, signed, sampled with each accepted beat.
  - bit = 1 when in_data >= thr (signed compare, full DATA_W, no saturation).
- Undefined: no thr port; threshold is fixed at 0 as above.
- Handshake and timing are identical in both builds.

Test Plan:
1. M=3, stream in_data = 5, -1, 0, out_ready=1 -> one cycle after the third beat: out_a=3'b101, out_fill=3, out_last=0; in_ready stays 1 throughout.
2. M=3, beats -7, 12 with in_last on 12 -> out_a=3'b010, out_fill=2, out_last=1; next word starts at idx 0.
3. M=3, out_ready=0, send 6 beats (-1,-1,-1,1,1,1):
   - First word 3'b000 holds.
   - in_ready drops only while the 6th beat is presented.
   - On raising out_ready: 3'b000 drains, then 3'b111 appears with no beat lost or duplicated.
4. Continuous in_valid and out_ready with random data over 300 beats -> a word every 3 cycles; reference-model compare of every out_a bit.
5. Assert rst for one cycle after 2 beats of a word -> all outputs 0 immediately (asynchronous). Next 3 beats (1,1,-1) give out_a=3'b011, out_fill=3.
6. BINARIZE_THRESH_EN build, thr=10: in_data 9, 10, -128 -> out_a=3'b010; thr=-128 with in_data=-128 -> bit 1.
